grade_stream_classifier: RTL and testbench

Sequential front end for the grading datapath. It accepts one student's four section grades as a serial byte stream over a valid/ready handshake and accumulates them into a 10-bit total. It classifies the total as failed, passed, or passed-with-scholarship and presents the verdict on a second valid/ready handshake. It also keeps saturating tallies of every verdict class since reset or the last clear.

---
 rtl/grade_stream_classifier.sv | 141 ++++++++++++++
 tb/tb_grade_stream_classifier.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/grade_stream_classifier.sv
// Serial grade accumulator: collects four section grades per student, classifies
// the total as failed / passed / scholarship, and keeps saturating verdict tallies.
module grade_stream_classifier #(
    parameter int PASS_TH  = 100,
    parameter int SCHOL_TH = 200,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             grade_valid,
    output logic             grade_ready,
    input  logic [7:0]       grade_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             failed,
    output logic             passed,
    output logic             scholarship,
    output logic [9:0]       total_sum,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] schol_cnt,
    input  logic             clear
);

    typedef enum logic {COLLECT, REPORT} state_t;

    localparam logic [9:0]       PASS_LIM  = 10'(PASS_TH);
    localparam logic [9:0]       SCHOL_LIM = 10'(SCHOL_TH);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t     state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    logic [9:0] acc_reg, acc_next;
    logic [9:0] total_reg, total_next;
    logic       failed_reg, failed_next;
    logic       passed_reg, passed_next;
    logic       schol_reg, schol_next;
    logic [9:0] sum;
    logic       grade_fire;
    logic       res_fire;

    // Both handshake-side outputs derive only from the state register, so
    // res_ready never reaches grade_ready combinationally.
    assign grade_ready = (state_reg == COLLECT);
    assign res_valid   = (state_reg == REPORT);
    assign grade_fire  = grade_valid && grade_ready;
    assign res_fire    = res_valid && res_ready;
    assign sum         = acc_reg + {2'b00, grade_data};

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        acc_next    = acc_reg;
        total_next  = total_reg;
        failed_next = failed_reg;
        passed_next = passed_reg;
        schol_next  = schol_reg;
        case (state_reg)
            COLLECT: begin
                if (grade_fire) begin
                    acc_next = sum;
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next  = REPORT;
                        total_next  = sum;
                        failed_next = (sum < PASS_LIM);
                        passed_next = (sum >= PASS_LIM);
                        schol_next  = (sum >= SCHOL_LIM);
                    end
                end
            end
            REPORT: begin
                // Verdict registers are zeroed on retirement so the outputs
                // read 0 whenever res_valid is low.
                if (res_fire) begin
                    state_next  = COLLECT;
                    idx_next    = 2'd0;
                    acc_next    = 10'd0;
                    total_next  = 10'd0;
                    failed_next = 1'b0;
                    passed_next = 1'b0;
                    schol_next  = 1'b0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= COLLECT;
            idx_reg    <= 2'd0;
            acc_reg    <= 10'd0;
            total_reg  <= 10'd0;
            failed_reg <= 1'b0;
            passed_reg <= 1'b0;
            schol_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            acc_reg    <= acc_next;
            total_reg  <= total_next;
            failed_reg <= failed_next;
            passed_reg <= passed_next;
            schol_reg  <= schol_next;
        end
    end

    assign total_sum   = total_reg;
    assign failed      = failed_reg;
    assign passed      = passed_reg;
    assign scholarship = schol_reg;

    // Tally slots: 0 = fail, 1 = pass, 2 = scholarship. Clear overrides any
    // increment landing in the same cycle.
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc = {schol_reg, passed_reg, failed_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tally
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (clear) begin
                    cnt_reg[gi] <= '0;
                end else if (res_fire && cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign fail_cnt  = cnt_reg[0];
    assign pass_cnt  = cnt_reg[1];
    assign schol_cnt = cnt_reg[2];

endmodule

// File: tb/tb_grade_stream_classifier.sv
// Directed bench for grade_stream_classifier: expected verdicts are queued when a
// record is sent and compared when the block presents them.
module tb_grade_stream_classifier;

    logic       clk;
    logic       rst_n;
    logic       grade_valid;
    logic       grade_ready;
    logic [7:0] grade_data;
    logic       res_valid;
    logic       res_ready;
    logic       failed;
    logic       passed;
    logic       scholarship;
    logic [9:0] total_sum;
    logic [7:0] fail_cnt;
    logic [7:0] pass_cnt;
    logic [7:0] schol_cnt;
    logic       clear;

    grade_stream_classifier #(.PASS_TH(100), .SCHOL_TH(200), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .grade_valid (grade_valid),
        .grade_ready (grade_ready),
        .grade_data  (grade_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .failed      (failed),
        .passed      (passed),
        .scholarship (scholarship),
        .total_sum   (total_sum),
        .fail_cnt    (fail_cnt),
        .pass_cnt    (pass_cnt),
        .schol_cnt   (schol_cnt),
        .clear       (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] total;
        logic       f;
        logic       p;
        logic       s;
    } verdict_t;

    verdict_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int exp_fail  = 0;
    int exp_pass  = 0;
    int exp_schol = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic chk_tallies(input string tag);
        chk({tag, "_fail_cnt"},  32'(fail_cnt),  32'(exp_fail));
        chk({tag, "_pass_cnt"},  32'(pass_cnt),  32'(exp_pass));
        chk({tag, "_schol_cnt"}, 32'(schol_cnt), 32'(exp_schol));
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic send_grade(input logic [7:0] g);
        int n = 0;
        grade_valid = 1'b1;
        grade_data  = g;
        while (grade_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("grade_ready_wait", 32'(grade_ready), 32'd1);
        @(posedge clk); #1;
        grade_valid = 1'b0;
        grade_data  = 8'd0;
    endtask

    // Sends one record, optionally clears mid-record, stalls the result for
    // 'hold' cycles, optionally clears on the result handshake, then retires it.
    task automatic run_record(input logic [7:0] g0, input logic [7:0] g1,
                              input logic [7:0] g2, input logic [7:0] g3,
                              input int hold, input bit clr_mid, input bit clr_hs);
        int       sum;
        verdict_t v;
        verdict_t got;
        sum     = int'(g0) + int'(g1) + int'(g2) + int'(g3);
        v.total = 10'(sum);
        v.f     = (sum < 100);
        v.p     = (sum >= 100);
        v.s     = (sum >= 200);
        exp_q.push_back(v);
        send_grade(g0);
        send_grade(g1);
        if (clr_mid) begin
            clear = 1'b1;
            exp_fail = 0; exp_pass = 0; exp_schol = 0;
        end
        send_grade(g2);
        clear = 1'b0;
        if (clr_mid) chk_tallies("clr_mid");
        send_grade(g3);
        chk("latency_res_valid", 32'(res_valid), 32'd1);
        chk("latency_grade_ready", 32'(grade_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            grade_valid = 1'b1;
            grade_data  = 8'hAA;
            @(posedge clk); #1;
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_grade_ready", 32'(grade_ready), 32'd0);
            chk("hold_total_sum", 32'(total_sum), 32'(v.total));
            chk("hold_failed", 32'(failed), 32'(v.f));
            chk_tallies("hold");
        end
        grade_valid = 1'b0;
        grade_data  = 8'd0;
        res_ready   = 1'b1;
        if (clr_hs) clear = 1'b1;
        #1;
        chk("no_comb_grade_ready", 32'(grade_ready), 32'd0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk("total_sum", 32'(total_sum), 32'(got.total));
            chk("failed", 32'(failed), 32'(got.f));
            chk("passed", 32'(passed), 32'(got.p));
            chk("scholarship", 32'(scholarship), 32'(got.s));
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        clear     = 1'b0;
        if (clr_hs) begin
            exp_fail = 0; exp_pass = 0; exp_schol = 0;
        end else begin
            if (v.f) exp_fail  = sat_inc(exp_fail);
            if (v.p) exp_pass  = sat_inc(exp_pass);
            if (v.s) exp_schol = sat_inc(exp_schol);
        end
        chk("post_res_valid", 32'(res_valid), 32'd0);
        chk("post_grade_ready", 32'(grade_ready), 32'd1);
        chk("post_total_sum", 32'(total_sum), 32'd0);
        chk("post_flags", 32'({failed, passed, scholarship}), 32'd0);
        chk_tallies("post");
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_grade_ready"}, 32'(grade_ready), 32'd1);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_flags"}, 32'({failed, passed, scholarship}), 32'd0);
        chk({tag, "_total_sum"}, 32'(total_sum), 32'd0);
        chk_tallies(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        grade_valid = 1'b0;
        grade_data  = 8'd0;
        res_ready   = 1'b0;
        clear       = 1'b0;
        #12;
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 60 -> failed
        run_record(8'd0, 8'd10, 8'd30, 8'd20, 0, 1'b0, 1'b0);
        chk("first_fail_cnt", 32'(fail_cnt), 32'd1);

        // 100 / 200 / 199 boundaries
        run_record(8'd25, 8'd25, 8'd25, 8'd25, 0, 1'b0, 1'b0);
        run_record(8'd50, 8'd50, 8'd50, 8'd50, 0, 1'b0, 1'b0);
        run_record(8'd62, 8'd81, 8'd37, 8'd19, 0, 1'b0, 1'b0);
        chk("bound_pass_cnt", 32'(pass_cnt), 32'd3);
        chk("bound_schol_cnt", 32'(schol_cnt), 32'd1);

        // 99 with backpressure and ignored grades while stalled
        run_record(8'd40, 8'd16, 8'd5, 8'd38, 6, 1'b0, 1'b0);

        // clear mid-record must not disturb the accumulation
        run_record(8'd100, 8'd0, 8'd0, 8'd1, 0, 1'b1, 1'b0);

        // maximum sum
        run_record(8'd255, 8'd255, 8'd255, 8'd255, 0, 1'b0, 1'b0);

        // fail tally saturation
        for (int i = 0; i < 259; i++) begin
            run_record(8'(i % 24), 8'(i % 24), 8'(i % 24), 8'(i % 24), 0, 1'b0, 1'b0);
        end
        chk("sat_fail_cnt", 32'(fail_cnt), 32'd255);

        // asynchronous reset mid-record
        send_grade(8'd90);
        send_grade(8'd90);
        #2;
        rst_n = 1'b0;
        exp_fail = 0; exp_pass = 0; exp_schol = 0;
        exp_q.delete();
        #1;
        chk_idle_zero("async_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_record(8'd86, 8'd75, 8'd49, 8'd93, 0, 1'b0, 1'b0);
        chk("after_rst_pass_cnt", 32'(pass_cnt), 32'd1);

        // clear coincident with a scholarship handshake wins
        run_record(8'd255, 8'd0, 8'd0, 8'd0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
